instruction_encoder: RTL and testbench

Pipelined instruction encoder that turns a one-hot instruction type plus operand fields into a 32-bit MIPS instruction word. It is the inverse of the core's one-hot instruction decoder and uses the same 31-entry bit assignment. It sits between the test/program-generation logic and the instruction-memory write port. Each accepted request produces one encoded word tagged with an auto-incrementing byte address, behind a valid/ready handshake with one register stage.

---
 rtl/instruction_encoder.sv | 143 ++++++++++++++
 tb/tb_instruction_encoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Pipelined MIPS instruction encoder: one-hot type plus operand fields in, one registered word out
// tagged with an auto-incrementing byte address. Define ENCODER_CHECK_EN to flag illegal types on `err`.
module instruction_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_type,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              addr_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
`ifdef ENCODER_CHECK_EN
    output logic              err,
`endif
    output logic [15:0]       word_cnt
);

    // Enum value equals the one-hot bit position; T_NONE stands for "no encodable type".
    typedef enum logic [4:0] {
        T_ADD, T_ADDU, T_SUB, T_SUBU, T_AND, T_OR, T_XOR, T_NOR,
        T_SLT, T_SLTU, T_SLL, T_SRL, T_SRA, T_SLLV, T_SRLV, T_SRAV, T_JR,
        T_ADDI, T_ADDIU, T_ANDI, T_ORI, T_XORI, T_LUI, T_LW, T_SW,
        T_BEQ, T_BNE, T_SLTI, T_SLTIU, T_J, T_JAL, T_NONE
    } type_e;

    function automatic logic [31:0] r_word(input logic [4:0] rs, rt, rd, sh, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, sh, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs, rt,
                                           input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    type_e             sel;
    logic [31:0]       enc;
    logic              legal;
    logic              in_fire;
    logic              out_fire;
    logic              emit;
    logic [ADDR_W-1:0] addr_cnt;

    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Lowest set bit wins; bit31 maps onto T_NONE so it encodes as a nop.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel = T_NONE;
        for (int i = 31; i >= 0; i--) begin
            if (in_type[i]) sel = type_e'(i[4:0]);
        end
    end

    always_comb begin
        enc = '0;
        case (sel)
            T_ADD:   enc = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h20);
            T_ADDU:  enc = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h21);
            T_SUB:   enc = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h22);
            T_SUBU:  enc = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h23);
            T_AND:   enc = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h24);
            T_OR:    enc = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h25);
            T_XOR:   enc = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h26);
            T_NOR:   enc = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h27);
            T_SLT:   enc = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h2A);
            T_SLTU:  enc = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h2B);
            T_SLL:   enc = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h00);
            T_SRL:   enc = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h02);
            T_SRA:   enc = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h03);
            T_SLLV:  enc = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h04);
            T_SRLV:  enc = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h06);
            T_SRAV:  enc = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h07);
            T_JR:    enc = r_word(in_rs, 5'd0, 5'd0, 5'd0, 6'h08);
            T_ADDI:  enc = i_word(6'h08, in_rs, in_rt, in_imm);
            T_ADDIU: enc = i_word(6'h09, in_rs, in_rt, in_imm);
            T_ANDI:  enc = i_word(6'h0C, in_rs, in_rt, in_imm);
            T_ORI:   enc = i_word(6'h0D, in_rs, in_rt, in_imm);
            T_XORI:  enc = i_word(6'h0E, in_rs, in_rt, in_imm);
            T_LUI:   enc = i_word(6'h0F, 5'd0, in_rt, in_imm);
            T_LW:    enc = i_word(6'h23, in_rs, in_rt, in_imm);
            T_SW:    enc = i_word(6'h2B, in_rs, in_rt, in_imm);
            T_BEQ:   enc = i_word(6'h04, in_rs, in_rt, in_imm);
            T_BNE:   enc = i_word(6'h05, in_rs, in_rt, in_imm);
            T_SLTI:  enc = i_word(6'h0A, in_rs, in_rt, in_imm);
            T_SLTIU: enc = i_word(6'h0B, in_rs, in_rt, in_imm);
            T_J:     enc = {6'h02, in_target};
            T_JAL:   enc = {6'h03, in_target};
            default: enc = '0;
        endcase
    end

`ifdef ENCODER_CHECK_EN
    assign legal = $onehot(in_type[30:0]) && !in_type[31];
`else
    assign legal = 1'b1;
`endif
    // Illegal requests complete the handshake but leave no word and no address step behind.
    assign emit = in_fire && legal;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= BASE_ADDR;
            addr_cnt  <= BASE_ADDR;
            word_cnt  <= '0;
        end else begin
            if (out_fire) word_cnt <= word_cnt + 16'd1;
            if (emit) begin
                out_valid <= 1'b1;
                out_instr <= enc;
                out_addr  <= addr_cnt;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
            // A clear wins over the increment of a word captured in the same cycle.
            if (addr_clr)  addr_cnt <= BASE_ADDR;
            else if (emit) addr_cnt <= addr_cnt + ADDR_W'(4);
        end
    end

`ifdef ENCODER_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                err <= 1'b0;
        else if (in_fire && !legal) err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: scoreboard of {word, address} pushed on acceptance
// and popped on each output transfer, plus per-scenario handshake and counter checks.
module tb_instruction_encoder;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [5:0] FUNCT [0:16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                           6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
    localparam logic [5:0] OPC [0:11] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                         6'h23, 6'h2B, 6'h04, 6'h05, 6'h0A, 6'h0B};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_type = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        addr_clr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic [15:0] word_cnt;
`ifdef ENCODER_CHECK_EN
    logic        err;
`endif

    instruction_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
        .in_target(in_target), .addr_clr(addr_clr), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
`ifdef ENCODER_CHECK_EN
        .err(err),
`endif
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    logic [63:0] sb[$];
    logic [31:0] model_addr = BASE;
    logic [15:0] model_cnt = '0;

    // Scoreboard consumer: an output transfer happens at the posedge after this negedge sample.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [63:0] e;
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL scoreboard_unexpected: got instr=%h addr=%h, expected no word", out_instr, out_addr);
            end else begin
                e = sb.pop_front();
                model_cnt++;
                if ({out_instr, out_addr} !== e)
                    $display("FAIL scoreboard_word: got instr=%h addr=%h, expected instr=%h addr=%h",
                             out_instr, out_addr, e[63:32], e[31:0]);
                else passes++;
            end
        end
    end

    function automatic logic [31:0] model(input int k, input logic [4:0] rs, rt, rd, sh,
                                          input logic [15:0] imm, input logic [25:0] tgt);
        if (k < 17) begin
            logic [4:0] r = (k >= 10 && k <= 12) ? 5'd0 : rs;
            logic [4:0] s = (k >= 10 && k <= 12) ? sh : 5'd0;
            if (k == 16) return {6'h00, rs, 5'd0, 5'd0, 5'd0, FUNCT[k]};
            return {6'h00, r, rt, rd, s, FUNCT[k]};
        end
        if (k < 29) return {OPC[k-17], (k == 22) ? 5'd0 : rs, rt, imm};
        return {(k == 29) ? 6'h02 : 6'h03, tgt};
    endfunction

    task automatic step();
        @(posedge clk); #2;
    endtask

    // Drive one request, wait (bounded) for acceptance, and record the expected word if one is due.
    task automatic send(input logic [31:0] t, input logic [4:0] rs, rt, rd, sh, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic [31:0] exp_instr, input bit clr, input bit emit);
        int n = 0;
        in_valid = 1'b1; in_type = t; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_imm = imm; in_target = tgt; addr_clr = clr;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
        end else begin
            if (emit) begin
                sb.push_back({exp_instr, model_addr});
                model_addr = model_addr + 32'd4;
            end
            if (clr) model_addr = BASE;
        end
        step();
        in_valid = 1'b0; addr_clr = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) $display("FAIL drain_timeout: %0d words outstanding, expected 0", sb.size());
        else passes++;
        checks++;
        if (word_cnt !== model_cnt) $display("FAIL word_cnt: got %0d, expected %0d", word_cnt, model_cnt);
        else passes++;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; addr_clr = 1'b0; out_ready = 1'b1;
        sb.delete(); model_addr = BASE; model_cnt = '0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_valid, in_ready, out_instr, out_addr, word_cnt} !== {1'b0, 1'b1, 32'h0, BASE, 16'h0})
            $display("FAIL reset_values: got valid=%b ready=%b instr=%h addr=%h cnt=%0d, expected 0 1 0 %h 0",
                     out_valid, in_ready, out_instr, out_addr, word_cnt, BASE);
        else passes++;
`ifdef ENCODER_CHECK_EN
        checks++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b, expected 0", err);
        else passes++;
`endif
    endtask

    task automatic test_add();
        send(32'h1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1820, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h0022_1820 || out_addr !== BASE)
            $display("FAIL add_latency: got valid=%b instr=%h addr=%h, expected 1 00221820 %h",
                     out_valid, out_instr, out_addr, BASE);
        else passes++;
        drain();
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(32'h1 << 17, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0005, 26'h0, 32'h2001_0005, 1'b0, 1'b1);
        checks++;
        if (in_ready !== 1'b1) $display("FAIL b2b_ready: got %b, expected 1", in_ready);
        else passes++;
        send(32'h1 << 23, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 32'h8FA8_0004, 1'b0, 1'b1);
        send(32'h1 << 30, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h100, 32'h0C00_0100, 1'b0, 1'b1);
        drain();
        checks++;
        if (word_cnt !== 16'd3) $display("FAIL b2b_word_cnt: got %0d, expected 3", word_cnt);
        else passes++;
    endtask

    task automatic test_addr_clr();
        send(32'h1 << 7, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 32'h0085_3027, 1'b0, 1'b1);
        checks++;
        if (out_addr !== 32'h0000_000C) $display("FAIL clr_pre_addr: got %h, expected 0000000c", out_addr);
        else passes++;
        send(32'h1 << 1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1821, 1'b1, 1'b1);
        checks++;
        if (out_addr !== 32'h0000_0010) $display("FAIL clr_same_cycle_addr: got %h, expected 00000010", out_addr);
        else passes++;
        send(32'h1 << 2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1822, 1'b0, 1'b1);
        checks++;
        if (out_addr !== BASE) $display("FAIL clr_next_addr: got %h, expected %h", out_addr, BASE);
        else passes++;
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        out_ready = 1'b0;
        send(32'h1 << 10, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 32'h0001_1100, 1'b0, 1'b1);
        held = out_addr;
        in_valid = 1'b1; in_type = 32'h1 << 16; in_rs = 5'd31; in_rt = 5'd9; in_rd = 5'd9; in_shamt = 5'd9;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== 32'h0001_1100 || out_addr !== held)
                $display("FAIL stall_hold[%0d]: got ready=%b valid=%b instr=%h addr=%h, expected 0 1 00011100 %h",
                         c, in_ready, out_valid, out_instr, out_addr, held);
            else passes++;
        end
        step();
        out_ready = 1'b1;
        send(32'h1 << 16, 5'd31, 5'd9, 5'd9, 5'd9, 16'h0, 26'h0, 32'h03E0_0008, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_all_types();
        for (int k = 0; k < 31; k++)
            send(32'h1 << k, 5'h11, 5'h12, 5'h13, 5'h14, 16'hBEEF, 26'h2AB_CDEF,
                 model(k, 5'h11, 5'h12, 5'h13, 5'h14, 16'hBEEF, 26'h2AB_CDEF), 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_type_errors();
        logic [31:0] addr_before;
`ifdef ENCODER_CHECK_EN
        send(32'h3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b1)
            $display("FAIL illegal_multi: got valid=%b err=%b, expected 0 1", out_valid, err);
        else passes++;
        send(32'h8000_0000, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        send(32'h0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
`else
        send(32'h3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1820, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h0022_1820)
            $display("FAIL multi_lowest_wins: got valid=%b instr=%h, expected 1 00221820", out_valid, out_instr);
        else passes++;
        send(32'h0, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h1, 32'h0, 1'b0, 1'b1);
        send(32'h8000_0000, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h1, 32'h0, 1'b0, 1'b1);
`endif
        addr_before = model_addr;
        send(32'h1 << 5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1825, 1'b0, 1'b1);
        checks++;
        if (out_addr !== addr_before) $display("FAIL type_err_addr: got %h, expected %h", out_addr, addr_before);
        else passes++;
        drain();
`ifdef ENCODER_CHECK_EN
        checks++;
        if (err !== 1'b1) $display("FAIL err_sticky: got %b, expected 1", err);
        else passes++;
`endif
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send(32'h1 << 22, 5'd9, 5'd3, 5'd0, 5'd0, 16'hABCD, 26'h0, 32'h3C03_ABCD, 1'b0, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_addr !== BASE || word_cnt !== 16'd0 || in_ready !== 1'b1)
            $display("FAIL async_reset: got valid=%b addr=%h cnt=%0d ready=%b, expected 0 %h 0 1",
                     out_valid, out_addr, word_cnt, in_ready, BASE);
        else passes++;
        sb.delete(); model_addr = BASE; model_cnt = '0; out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        send(32'h1 << 3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1823, 1'b0, 1'b1);
        checks++;
        if (out_addr !== BASE) $display("FAIL post_reset_addr: got %h, expected %h", out_addr, BASE);
        else passes++;
        drain();
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_addr_clr();
        test_backpressure();
        test_all_types();
        test_type_errors();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
